// File: rtl/stepper_sequencer.sv
// Four-coil stepper sequencer: accepts one move command at a time and issues the
// requested number of full- or half-steps at a programmed rate, then pulses done.
module stepper_sequencer #(
  parameter int PERIOD_W   = 16,
  parameter int COUNT_W    = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic                abort,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  steps_left,
  output logic [2:0]          pos,
  output logic [3:0]          drive,
  output logic                fsm_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly in IDLE, and commands offered while RUN are dropped.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] cnt, period_q, eff_period;
  logic                dir_q, half_q, moved;
  logic                accept, tick, finish, done_nxt, energised;
  logic [2:0]          step_pos;
  logic [3:0]          coil;

  assign eff_period = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tick      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_steps != '0) state_nxt = RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident tick: no step is taken on that edge.
        if (abort) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (cnt == PERIOD_W'(1)) begin
          tick = 1'b1;
          if (steps_left == COUNT_W'(1)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_nxt = finish | (accept & (cmd_steps == '0));

  // Full-step from an odd (half) position moves only one slot, to realign on even.
  always_comb begin
    step_pos = pos;
    if (half_q || pos[0]) step_pos = dir_q ? (pos - 3'd1) : (pos + 3'd1);
    else                  step_pos = dir_q ? (pos - 3'd2) : (pos + 3'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos        <= 3'd0;
      steps_left <= '0;
      cnt        <= '0;
      period_q   <= '0;
      dir_q      <= 1'b0;
      half_q     <= 1'b0;
      moved      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= done_nxt;
      if (accept) begin
        steps_left <= cmd_steps;
        cnt        <= eff_period;
        period_q   <= eff_period;
        dir_q      <= cmd_dir;
        half_q     <= cmd_half;
        if (cmd_steps != '0) moved <= 1'b1;
      end else if (tick) begin
        pos        <= step_pos;
        steps_left <= steps_left - COUNT_W'(1);
        cnt        <= period_q;
      end else if (state == RUN && !abort) begin
        cnt <= cnt - PERIOD_W'(1);
      end
    end
  end

  // Coils stay off after reset until a real move has happened.
  assign energised = (state == RUN) || (moved && hold);

  always_comb begin
    coil = 4'b0000;
    if (energised) begin
      case (pos)
        3'd0:    coil = 4'b0001;
        3'd1:    coil = 4'b0011;
        3'd2:    coil = 4'b0010;
        3'd3:    coil = 4'b0110;
        3'd4:    coil = 4'b0100;
        3'd5:    coil = 4'b1100;
        3'd6:    coil = 4'b1000;
        default: coil = 4'b1001;
      endcase
    end
  end

  assign drive     = ACTIVE_LOW ? ~coil : coil;
  assign busy      = (state == RUN);
  assign cmd_ready = (state == IDLE);
  assign fsm_state = state;

endmodule
